pcie_cfg_mgmt_arb: RTL
======================

# pcie_cfg_mgmt_arb

Round-robin arbiter and sequencer that shares the single PCIe hard-IP configuration management port (cfg_mgmt_*) among several internal requesters, such as the host-register bridge, a link-status poller and a debug engine. It accepts one request at a time and drives the read/write strobe until the IP returns done. It returns read data or a timeout indication to the granted requester. It sits between the benchmark core's control logic and the PCIe IP cfg_mgmt pins.

## Interface
Parameters:
- PORTS, 4, number of requesters (1-16)
- ADDR_WIDTH, 10, cfg_mgmt_addr width (DWORD address)
- FUNC_WIDTH, 8, cfg_mgmt_function_number width
- TIMEOUT, 1023, cycles to wait for done before aborting (≥2)
- TIMEOUT_WIDTH, $clog2(TIMEOUT+1), counter width

Ports:
- clk  in  1  clock (PCIe user clock, 250 MHz)
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- s_req_addr  in  PORTS*ADDR_WIDTH  per-port register address, packed, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- s_req_func  in  PORTS*FUNC_WIDTH  per-port function number
- s_req_write  in  PORTS  1=write, 0=read
- s_req_data  in  PORTS*32  write data
- s_req_be  in  PORTS*4  write byte enables
- s_req_valid  in  PORTS  request valid; held with fields stable until ready
- s_req_ready  out  PORTS  one-hot accept pulse
- s_rsp_data  out  32  shared response data; meaningful only with s_rsp_valid
- s_rsp_valid  out  PORTS  one-hot, single-cycle completion pulse
- s_rsp_timeout  out  1  qualifies s_rsp_valid: 1=aborted by timeout
- cfg_mgmt_addr  out  ADDR_WIDTH  to IP
- cfg_mgmt_function_number  out  FUNC_WIDTH  to IP
- cfg_mgmt_write  out  1  write strobe, held until done
- cfg_mgmt_write_data  out  32  to IP
- cfg_mgmt_byte_enable  out  4  to IP
- cfg_mgmt_read  out  1  read strobe, held until done
- cfg_mgmt_read_data  in  32  from IP, valid with done
- cfg_mgmt_read_write_done  in  1  completion from IP

## Operation
- FSM states: IDLE, ACTIVE, RESP.
- IDLE: if any s_req_valid, grant = first set bit searching upward from (last_grant+1) mod PORTS. s_req_ready[grant]=1 combinationally in that cycle. Capture addr/func/write/data/be into output registers, set cfg_mgmt_read or cfg_mgmt_write per s_req_write, clear the timeout counter, and go to ACTIVE. Update last_grant.
- ACTIVE: strobe held, counter increments each cycle.
  - On done: drop strobe, latch cfg_mgmt_read_data (writes latch 0), and go to RESP with timeout=0.
  - If the counter reaches TIMEOUT-1 with no done: drop strobe, load data=32'hFFFFFFFF, and go to RESP with timeout=1.
  - If done and the timeout condition occur in the same cycle, done wins.
- RESP: s_rsp_valid[grant]=1 and s_rsp_timeout for one cycle, then IDLE. No new grant is issued in RESP.
- done is ignored outside ACTIVE, including a late done after a timeout.
- cfg_mgmt_addr/func/data/be keep their last value when idle. Only the strobes are guaranteed low.
- Invariant: cfg_mgmt_read & cfg_mgmt_write never both 1.
- last_grant resets to PORTS-1, so port 0 has first priority after reset.

## Timing
- Reset (asynchronous assert, synchronous-release assumed upstream):
  - state=IDLE.
  - All outputs 0: s_req_ready, s_rsp_valid, s_rsp_timeout, s_rsp_data, all cfg_mgmt_* outputs.
- Reset mid-operation: strobe drops immediately and no response is ever issued for the in-flight request.
- Accept at cycle T (valid&ready) → strobe high T+1 … through the cycle done is sampled (T+1+k, k≥0) → strobe low T+2+k, rsp pulse T+2+k, next accept earliest T+3+k, next strobe T+4+k.
- Strobes are always separated by ≥2 low cycles.
- Timeout: strobe high for exactly TIMEOUT cycles (T+1 … T+TIMEOUT), rsp pulse at T+TIMEOUT+1.
- s_req_ready is never asserted outside IDLE, and at most one bit is asserted.

## Test plan
- Single read on port 2, IP returns done with data 32'hDEADBEEF 3 cycles after strobe rises → cfg_mgmt_read high exactly 4 cycles with addr/func from port 2, then s_rsp_valid=4'b0100, s_rsp_data=32'hDEADBEEF, s_rsp_timeout=0.
- Write on port 0 with addr 10'h004, data 32'h12345678, be 4'hF, done on the first strobe cycle → cfg_mgmt_write high 1 cycle with those values, cfg_mgmt_read stays 0, s_rsp_valid=4'b0001.
- All 4 ports hold valid continuously, done after 1 cycle each time → grants 0,1,2,3,0 in order, one ready pulse per accept, accepts exactly 4 cycles apart.
- TIMEOUT=16, no done → strobe high 16 cycles, then s_rsp_valid with s_rsp_timeout=1 and data 32'hFFFFFFFF. A done injected 2 cycles later produces no response; the next request completes normally.
- Done in the same cycle as the final timeout cycle → s_rsp_timeout=0, read data returned.
- rst_n asserted while ACTIVE → cfg_mgmt_read falls without a clock edge and all outputs are 0. After release, port 0 wins when all ports request.

Source files
------------

// File: rtl/pcie_cfg_mgmt_arb.sv
// Round-robin arbiter that shares the PCIe hard-IP cfg_mgmt port among PORTS requesters.
// One request is in flight at a time; the granted requester gets data or a timeout pulse back.
module pcie_cfg_mgmt_arb #(
    parameter int PORTS         = 4,
    parameter int ADDR_WIDTH    = 10,
    parameter int FUNC_WIDTH    = 8,
    parameter int TIMEOUT       = 1023,
    parameter int TIMEOUT_WIDTH = $clog2(TIMEOUT + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PORTS*ADDR_WIDTH-1:0]  s_req_addr,
    input  logic [PORTS*FUNC_WIDTH-1:0]  s_req_func,
    input  logic [PORTS-1:0]             s_req_write,
    input  logic [PORTS*32-1:0]          s_req_data,
    input  logic [PORTS*4-1:0]           s_req_be,
    input  logic [PORTS-1:0]             s_req_valid,
    output logic [PORTS-1:0]             s_req_ready,
    output logic [31:0]                  s_rsp_data,
    output logic [PORTS-1:0]             s_rsp_valid,
    output logic                         s_rsp_timeout,
    output logic [ADDR_WIDTH-1:0]        cfg_mgmt_addr,
    output logic [FUNC_WIDTH-1:0]        cfg_mgmt_function_number,
    output logic                         cfg_mgmt_write,
    output logic [31:0]                  cfg_mgmt_write_data,
    output logic [3:0]                   cfg_mgmt_byte_enable,
    output logic                         cfg_mgmt_read,
    input  logic [31:0]                  cfg_mgmt_read_data,
    input  logic                         cfg_mgmt_read_write_done
);

    localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int DW = 32;
    localparam int BW = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]               state_r;
    logic [GW-1:0]            last_grant_r;
    logic [GW-1:0]            grant_r;
    logic [TIMEOUT_WIDTH-1:0] cnt_r;
    logic                     found_s;
    logic [GW-1:0]            pick_s;
    logic                     accept_s;
    logic                     expire_s;

    function automatic logic [PORTS-1:0] onehot(input logic [GW-1:0] idx);
        logic [PORTS-1:0] v;
        for (int i = 0; i < PORTS; i++) begin
            v[i] = (idx == GW'(i));
        end
        return v;
    endfunction

    // Search upward from one past the last grant; first requester hit wins.
    always_comb begin
        found_s = 1'b0;
        pick_s  = {GW{1'b0}};
        for (int k = 0; k < PORTS; k++) begin
            logic [GW-1:0] idx;
            logic          hit;
            idx     = GW'((int'(last_grant_r) + k + 32'sd1) % PORTS);
            hit     = s_req_valid[idx] && !found_s;
            pick_s  = hit ? idx : pick_s;
            found_s = found_s | hit;
        end
    end

    assign accept_s    = (state_r == ST_IDLE) && found_s;
    assign expire_s    = (cnt_r == TIMEOUT_WIDTH'(TIMEOUT - 1));
    assign s_req_ready = (accept_s && rst_n) ? onehot(pick_s) : {PORTS{1'b0}};

    // Request sequencing: capture on accept, hold strobe until done or timeout, then respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r                  <= ST_IDLE;
            last_grant_r             <= GW'(PORTS - 1);
            grant_r                  <= {GW{1'b0}};
            cnt_r                    <= {TIMEOUT_WIDTH{1'b0}};
            s_rsp_data               <= 32'h0000_0000;
            s_rsp_valid              <= {PORTS{1'b0}};
            s_rsp_timeout            <= 1'b0;
            cfg_mgmt_addr            <= {ADDR_WIDTH{1'b0}};
            cfg_mgmt_function_number <= {FUNC_WIDTH{1'b0}};
            cfg_mgmt_write           <= 1'b0;
            cfg_mgmt_write_data      <= 32'h0000_0000;
            cfg_mgmt_byte_enable     <= 4'h0;
            cfg_mgmt_read            <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    s_rsp_valid   <= {PORTS{1'b0}};
                    s_rsp_timeout <= 1'b0;
                    if (accept_s) begin
                        grant_r                  <= pick_s;
                        last_grant_r             <= pick_s;
                        cfg_mgmt_addr            <= s_req_addr[int'(pick_s)*ADDR_WIDTH +: ADDR_WIDTH];
                        cfg_mgmt_function_number <= s_req_func[int'(pick_s)*FUNC_WIDTH +: FUNC_WIDTH];
                        cfg_mgmt_write_data      <= s_req_data[int'(pick_s)*DW +: DW];
                        cfg_mgmt_byte_enable     <= s_req_be[int'(pick_s)*BW +: BW];
                        cfg_mgmt_write           <= s_req_write[pick_s];
                        cfg_mgmt_read            <= !s_req_write[pick_s];
                        cnt_r                    <= {TIMEOUT_WIDTH{1'b0}};
                        state_r                  <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // done takes priority over an expiring counter in the same cycle
                    if (cfg_mgmt_read_write_done) begin
                        s_rsp_data     <= cfg_mgmt_write ? 32'h0000_0000 : cfg_mgmt_read_data;
                        s_rsp_timeout  <= 1'b0;
                        s_rsp_valid    <= onehot(grant_r);
                        cfg_mgmt_read  <= 1'b0;
                        cfg_mgmt_write <= 1'b0;
                        state_r        <= ST_RESP;
                    end else if (expire_s) begin
                        s_rsp_data     <= 32'hFFFF_FFFF;
                        s_rsp_timeout  <= 1'b1;
                        s_rsp_valid    <= onehot(grant_r);
                        cfg_mgmt_read  <= 1'b0;
                        cfg_mgmt_write <= 1'b0;
                        state_r        <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + TIMEOUT_WIDTH'(1);
                    end
                end
                ST_RESP: begin
                    s_rsp_valid   <= {PORTS{1'b0}};
                    s_rsp_timeout <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    s_rsp_valid    <= {PORTS{1'b0}};
                    s_rsp_timeout  <= 1'b0;
                    cfg_mgmt_read  <= 1'b0;
                    cfg_mgmt_write <= 1'b0;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
